// File: rtl/imem_access_arbiter.sv
// imem_access_arbiter
// Sole owner of the instruction memory port. Each cycle it grants at most one
// access, either a fetch read or a loader write. It converts byte addresses
// into the memory's indexing, checks every access for alignment and range,
// and registers the fetch read data.
//
// Handshake: a requester holds req together with addr (and data for the
// loader) until it sees gnt high in the same cycle. A granted access is
// consumed in that cycle. A fetch response (rvalid/rdata/err) appears exactly
// one cycle after its grant. The fetch side has no back-pressure on the
// response.
//
// Arbitration modes (the current mode is visible on dbg_state_o):
//   RUN   : fetch has priority. The loader gets the slot when fetch is idle,
//           or once it has been kept waiting STARVE_MAX cycles in a row.
//   LOCK  : the loader owns the port for a program download. Fetch is held off.
//   DRAIN : a single quiet cycle before the arbiter returns to RUN.
module imem_access_arbiter #(
    parameter int          NENTRIES   = 128,
    parameter int          STARVE_MAX = 4,
    parameter logic [31:0] ERR_INSN   = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    // fetch unit (reads)
    input  logic        fetch_req_i,
    input  logic [31:0] fetch_addr_i,
    output logic        fetch_gnt_o,
    output logic        fetch_rvalid_o,
    output logic [31:0] fetch_rdata_o,
    output logic        fetch_err_o,
    // program loader (writes)
    input  logic        load_lock_i,
    input  logic        load_req_i,
    input  logic [31:0] load_addr_i,
    input  logic [31:0] load_data_i,
    output logic        load_gnt_o,
    output logic        load_err_o,
    output logic [15:0] load_cnt_o,
    // instruction memory
    output logic        mem_re_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    // arbitration mode: 0 RUN, 1 LOCK, 2 DRAIN
    output logic [1:0]  dbg_state_o
);

    localparam int          SW        = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [29:0] IDX_LIMIT = 30'(NENTRIES);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LOCK  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [SW-1:0] starve_q;
    logic          fetch_gnt;
    logic          load_gnt;
    logic          fetch_legal;
    logic          load_legal;
    logic          load_win_run;

    // An access is legal when it is word aligned and its word index is in range.
    function automatic logic addr_legal(input logic [31:0] addr);
        return (addr[1:0] == 2'b00) && (addr[31:2] < IDX_LIMIT);
    endfunction

    assign fetch_legal = addr_legal(fetch_addr_i);
    assign load_legal  = addr_legal(load_addr_i);

    // In RUN the loader takes the slot when fetch is idle or when it has starved.
    assign load_win_run = load_req_i && (!fetch_req_i || (starve_q == STARVE_LIM));

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. DRAIN always lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (load_lock_i) state_d = ST_LOCK;
            ST_LOCK:  if (!load_lock_i) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // Grant outputs per mode. Nothing is granted while reset is asserted, so
    // the memory cannot be written during reset.
    always_comb begin
        fetch_gnt = 1'b0;
        load_gnt  = 1'b0;
        if (rst_ni) begin
            case (state_q)
                ST_RUN: begin
                    if (load_win_run) begin
                        load_gnt = 1'b1;
                    end else if (fetch_req_i) begin
                        fetch_gnt = 1'b1;
                    end
                end
                ST_LOCK:  load_gnt = load_req_i;
                default: begin
                    fetch_gnt = 1'b0;
                    load_gnt  = 1'b0;
                end
            endcase
        end
    end

    assign fetch_gnt_o = fetch_gnt;
    assign load_gnt_o  = load_gnt;
    assign dbg_state_o = state_q;

    // Memory port drive. Illegal accesses are granted but never reach the
    // memory. Reads present the byte address (the memory indexes [21:2]).
    // Writes present the word index (the write port indexes directly).
    always_comb begin
        mem_re_o    = fetch_gnt && fetch_legal;
        mem_we_o    = load_gnt && load_legal;
        mem_addr_o  = 32'h0;
        mem_wdata_o = 32'h0;
        if (load_gnt) begin
            mem_addr_o = {2'b00, load_addr_i[31:2]};
        end else if (fetch_gnt) begin
            mem_addr_o = fetch_addr_i;
        end
        if (mem_we_o) begin
            mem_wdata_o = load_data_i;
        end
    end

    // Starvation counter. It counts cycles in which the loader waits without
    // a grant, saturates at the limit, and clears when the loader is granted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_q <= '0;
        end else if (load_gnt) begin
            starve_q <= '0;
        end else if (load_req_i && (starve_q != STARVE_LIM)) begin
            starve_q <= starve_q + 1'b1;
        end
    end

    // Fetch response register. Data and error update only on a grant and
    // otherwise hold their last value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_rvalid_o <= 1'b0;
            fetch_rdata_o  <= 32'h0;
            fetch_err_o    <= 1'b0;
        end else begin
            fetch_rvalid_o <= fetch_gnt;
            if (fetch_gnt) begin
                fetch_rdata_o <= fetch_legal ? mem_rdata_i : ERR_INSN;
                fetch_err_o   <= !fetch_legal;
            end
        end
    end

    // Loader error pulse: the write was granted but suppressed as illegal.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            load_err_o <= 1'b0;
        end else begin
            load_err_o <= load_gnt && !load_legal;
        end
    end

    // Download word counter. It clears on entry to LOCK, counts legal writes
    // during LOCK, and holds outside LOCK.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            load_cnt_o <= 16'h0;
        end else if ((state_q != ST_LOCK) && (state_d == ST_LOCK)) begin
            load_cnt_o <= 16'h0;
        end else if ((state_q == ST_LOCK) && mem_we_o && (load_cnt_o != 16'hFFFF)) begin
            load_cnt_o <= load_cnt_o + 16'h1;
        end
    end

endmodule
